practice: RTL and testbench

PRACTICE -- requirements
Module: practice

---
 rtl/practice.sv | 42 ++++
 tb/tb_practice.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/practice.sv
// 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) with step enable, seed load under reset
// and lock-up recovery from the all-zero state; out is the MSB of the state.
module practice (
   input  logic clk,
   input  logic rst,
   input  logic ena,
   input  logic seed,
   output logic out
);

   localparam int unsigned W = 8;
   localparam logic [W-1:0] TAPS = 8'hB8;

   logic [W-1:0] s;
   logic [W-1:0] s_next;
   logic         fb;

   // State register; the seed only lands in bit 0, so out is 0 after reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         s <= {(W-1)'(0), seed};
      end else begin
         s <= s_next;
      end
   end

   // Next state: shift in the tap parity, or escape the all-zero lock-up state
   always_comb begin
      s_next = s;
      fb     = ^(s & TAPS);
      if (ena) begin
         if (s == '0) begin
            s_next = W'(1);
         end else begin
            s_next = {s[W-2:0], fb};
         end
      end
   end

   assign out = s[W-1];

endmodule

// File: tb/tb_practice.sv
// Self-checking bench for practice: randomized stimulus against a sequence-level
// reference model, with s and out compared after every rising edge.
module tb_practice;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic ena = 1'b0;
   logic seed = 1'b0;
   logic out;
   logic [7:0] obs_s;

   int n_cmp = 0;
   int n_err = 0;
   logic [7:0] model_s;

   practice dut (
      .clk  (clk),
      .rst  (rst),
      .ena  (ena),
      .seed (seed),
      .out  (out)
   );

   assign obs_s = dut.s;

   always #5 clk = ~clk;

   // Next value as defined by the polynomial rule: double mod 256, add parity of taps 7,5,4,3
   function automatic logic [7:0] ref_next(input logic [7:0] v);
      int taps[4] = '{7, 5, 4, 3};
      int ones = 0;
      int nxt;
      if (v == 8'd0) return 8'd1;
      foreach (taps[k]) ones += int'(v[taps[k]]);
      nxt = (int'(v) * 2) % 256 + (ones % 2);
      return 8'(nxt);
   endfunction

   // Drive inputs away from the edge, take one rising edge, advance the model, settle
   task automatic cycle(input logic r, input logic e, input logic sd);
      @(negedge clk);
      rst = r; ena = e; seed = sd;
      @(posedge clk);
      if (!r) model_s = {7'd0, sd};
      else if (e) model_s = ref_next(model_s);
      #1;
   endtask

   task automatic test_reset();
      cycle(1'b0, 1'b0, 1'b1);
      n_cmp++; if (obs_s !== 8'h01) begin n_err++; $display("FAIL reset_s1: got %h want 01", obs_s); end
      n_cmp++; if (out !== 1'b0) begin n_err++; $display("FAIL reset_out1: got %b want 0", out); end
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, 1'b0, 1'($urandom));
         n_cmp++; if (obs_s !== 8'h01) begin n_err++; $display("FAIL hold_%0d: got %h want 01", i, obs_s); end
         n_cmp++; if (out !== 1'b0) begin n_err++; $display("FAIL hold_out_%0d: got %b want 0", i, out); end
      end
   endtask

   task automatic test_known_sequence();
      logic [7:0] exp_seq[7] = '{8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47, 8'h8E};
      cycle(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 7; i++) begin
         cycle(1'b1, 1'b1, 1'($urandom));
         n_cmp++; if (obs_s !== exp_seq[i]) begin n_err++; $display("FAIL seq_%0d: got %h want %h", i, obs_s, exp_seq[i]); end
         n_cmp++; if (out !== (i == 6)) begin n_err++; $display("FAIL seq_out_%0d: got %b want %b", i, out, (i == 6)); end
      end
   endtask

   task automatic test_seed_zero();
      cycle(1'b0, 1'b1, 1'b0);
      n_cmp++; if (obs_s !== 8'h00) begin n_err++; $display("FAIL seed0_reset: got %h want 00", obs_s); end
      n_cmp++; if (out !== 1'b0) begin n_err++; $display("FAIL seed0_out: got %b want 0", out); end
      cycle(1'b1, 1'b1, 1'b0);
      n_cmp++; if (obs_s !== 8'h01) begin n_err++; $display("FAIL seed0_recover: got %h want 01", obs_s); end
      for (int i = 0; i < 10; i++) begin
         cycle(1'b1, 1'b1, 1'($urandom));
         n_cmp++; if (obs_s !== model_s || out !== model_s[7]) begin
            n_err++; $display("FAIL seed0_run_%0d: got s=%h out=%b want s=%h out=%b", i, obs_s, out, model_s, model_s[7]);
         end
      end
   endtask

   task automatic test_period();
      bit seen[256];
      foreach (seen[k]) seen[k] = 1'b0;
      cycle(1'b0, 1'b0, 1'b1);
      seen[1] = 1'b1;
      for (int i = 1; i <= 255; i++) begin
         cycle(1'b1, 1'b1, 1'($urandom));
         n_cmp++; if (obs_s !== model_s || out !== model_s[7]) begin
            n_err++; $display("FAIL period_model_%0d: got s=%h out=%b want s=%h", i, obs_s, out, model_s);
         end
         if (i < 255) begin
            n_cmp++; if (obs_s === 8'h00 || seen[obs_s]) begin
               n_err++; $display("FAIL period_repeat_%0d: got s=%h want new nonzero value", i, obs_s);
            end
            if (!$isunknown(obs_s)) seen[obs_s] = 1'b1;
         end
      end
      n_cmp++; if (obs_s !== 8'h01) begin n_err++; $display("FAIL period_wrap: got %h want 01", obs_s); end
   endtask

   task automatic test_ena_toggle();
      logic pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      logic [7:0] prev;
      for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) begin
         prev = obs_s;
         cycle(1'b1, pat[i], 1'($urandom));
         n_cmp++; if (obs_s !== (pat[i] ? ref_next(prev) : prev) || obs_s !== model_s || out !== model_s[7]) begin
            n_err++; $display("FAIL toggle_%0d: got s=%h out=%b want s=%h", i, obs_s, out, model_s);
         end
      end
   endtask

   task automatic test_mid_reset();
      for (int i = 0; i < 9; i++) cycle(1'b1, 1'b1, 1'b0);
      cycle(1'b0, 1'b1, 1'b1);
      n_cmp++; if (obs_s !== 8'h01 || out !== 1'b0) begin
         n_err++; $display("FAIL midreset: got s=%h out=%b want s=01 out=0", obs_s, out);
      end
      cycle(1'b1, 1'b1, 1'b0);
      n_cmp++; if (obs_s !== 8'h02 || out !== 1'b0) begin
         n_err++; $display("FAIL midreset_resume: got s=%h out=%b want s=02 out=0", obs_s, out);
      end
   endtask

   task automatic test_random();
      logic r, e, sd;
      for (int i = 0; i < 400; i++) begin
         r  = ($urandom_range(0, 19) != 0);
         e  = ($urandom_range(0, 3) != 0);
         sd = 1'($urandom);
         cycle(r, e, sd);
         n_cmp++; if (obs_s !== model_s || out !== model_s[7]) begin
            n_err++; $display("FAIL random_%0d: got s=%h out=%b want s=%h out=%b", i, obs_s, out, model_s, model_s[7]);
         end
      end
   endtask

   initial begin
      model_s = 8'h00;
      test_reset();
      test_known_sequence();
      test_seed_zero();
      test_period();
      test_ena_toggle();
      test_mid_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
